// File: rtl/scc_plus_gen.sv
// rtl/scc_plus_gen.sv - SCC/SCC+ wavetable sound generator with signed mixed PCM output
// Five 32-byte wave channels, 12-bit period counters, 16-tick mix frame.
module scc_plus_gen #(
    parameter int CH_NUM   = 5,
    parameter int OUT_W    = 11,
    parameter int FREQ_MIN = 9
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             CLK_EN,
    input  logic             SCC_PLUS,
    input  logic             CS_n,
    input  logic             WR_n,
    input  logic             RD_n,
    input  logic [7:0]       ADDR,
    input  logic [7:0]       DIN,
    output logic [7:0]       DOUT,
    output logic             BUSDIR_n,
    output logic [OUT_W-1:0] OUT
);

    localparam logic [4:0] PRESENT = 5'((1 << CH_NUM) - 1);

    logic [7:0]        wave_ram [5][32];
    logic [11:0]       period   [5];
    logic [3:0]        vol      [5];
    logic [11:0]       cnt      [5];
    logic [4:0]        wptr     [5];
    logic signed [7:0] pcm      [5];
    logic [4:0]        en_mask;
    logic [1:0]        def_lock;
    logic              def_rst;
    logic [1:0]        def_nib;
    logic [3:0]        frame;
    logic              wr_seen;

    logic              wr_stb, rd_act, rd_map, rd_ok;
    logic              reg_hit, def_hit, reg_we, def_we;
    logic [4:0]        wr_mask, wave_we, lock;
    logic [2:0]        rd_ch;
    logic [7:0]        rd_byte;
    logic [4:0]        freq_we, vol_we;
    logic [11:0]       per_new  [5];
    logic [11:0]       cnt_nxt  [5];
    logic [7:0]        fetch    [5];
    logic signed [11:0] prod    [5];
    logic signed [7:0] pcm_next [5];
    logic [3:0]        prod_frac_unused [5];
    logic signed [OUT_W-1:0] mix;

    // Bus decode; lock bit 0 covers ch0-3, bit 1 covers ch4, absent channels always locked
    always_comb begin
        wr_stb = !CS_n && !WR_n && !wr_seen;
        rd_act = !CS_n && !RD_n;
        lock   = {def_lock[1], {4{def_lock[0]}}} | ~PRESENT;
        if (SCC_PLUS) begin
            wr_mask = (ADDR < 8'hA0) ? (5'd1 << ADDR[7:5]) : 5'd0;
            rd_map  = ADDR < 8'hA0;
            rd_ch   = rd_map ? ADDR[7:5] : 3'd0;
            reg_hit = ADDR[7:5] == 3'd5;
            def_hit = ADDR[7:5] == 3'd6;
        end else begin
            wr_mask = ADDR[7] ? 5'd0 :
                      (ADDR[6:5] == 2'd3) ? 5'b11000 : (5'd1 << ADDR[6:5]);
            rd_map  = !ADDR[7] || ADDR[7:5] == 3'd5;
            rd_ch   = ADDR[7] ? 3'd4 : {1'b0, ADDR[6:5]};
            reg_hit = ADDR[7:5] == 3'd4;
            def_hit = ADDR[7:5] == 3'd7;
        end
        wave_we = wr_stb ? (wr_mask & ~lock) : 5'd0;
        rd_ok   = rd_act && rd_map && !lock[rd_ch];
        rd_byte = wave_ram[rd_ch][ADDR[4:0]];
        reg_we  = wr_stb && reg_hit;
        def_we  = wr_stb && def_hit;
    end

    always_comb begin
        for (int c = 0; c < 5; c++) begin
            freq_we[c] = reg_we && PRESENT[c] && ADDR[3:1] == 3'(c) && ADDR[3:0] < 4'd10;
            vol_we[c]  = reg_we && PRESENT[c] && ADDR[3:0] == 4'(c + 10);
            per_new[c] = ADDR[0] ? {DIN[3:0], period[c][7:0]} : {period[c][11:8], DIN};
            cnt_nxt[c] = cnt[c] - 12'd1;
            if (def_nib[0])
                cnt_nxt[c][7:4] = cnt[c][7:4] - 4'd1;
            if (def_nib[1])
                cnt_nxt[c][11:8] = cnt[c][11:8] - 4'd1;
            // A CPU write landing on the byte being fetched takes priority
            fetch[c] = (wave_we[c] && ADDR[4:0] == wptr[c]) ? DIN : wave_ram[c][wptr[c]];
            prod[c]  = $signed(fetch[c]) * $signed({1'b0, vol[c]});
            {pcm_next[c], prod_frac_unused[c]} = en_mask[c] ? prod[c] : 12'sd0;
        end
        mix = '0;
        for (int c = 0; c < 5; c++)
            mix = mix + {{(OUT_W-8){pcm[c][7]}}, pcm[c]};
    end

    always_ff @(posedge CLK) begin
        for (int c = 0; c < 5; c++)
            if (wave_we[c])
                wave_ram[c][ADDR[4:0]] <= DIN;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int c = 0; c < 5; c++) begin
                period[c] <= '0;
                vol[c]    <= '0;
                cnt[c]    <= '0;
                wptr[c]   <= '0;
                pcm[c]    <= '0;
            end
            en_mask  <= '0;
            def_lock <= '0;
            def_rst  <= 1'b0;
            def_nib  <= '0;
            frame    <= '0;
            wr_seen  <= 1'b0;
            OUT      <= '0;
            DOUT     <= '0;
            BUSDIR_n <= 1'b1;
        end else begin
            wr_seen  <= !CS_n && !WR_n;
            BUSDIR_n <= !rd_ok;
            DOUT     <= rd_ok ? rd_byte : 8'd0;
            if (reg_we && ADDR[3:0] == 4'hF)
                en_mask <= DIN[4:0] & PRESENT;
            if (def_we) begin
                def_lock <= DIN[7:6];
                def_rst  <= DIN[5];
                def_nib  <= DIN[1:0];
            end
            for (int c = 0; c < 5; c++) begin
                if (freq_we[c])
                    period[c] <= per_new[c];
                if (vol_we[c])
                    vol[c] <= DIN[3:0];
                if (freq_we[c] && def_rst) begin
                    cnt[c]  <= per_new[c];
                    wptr[c] <= '0;
                end else if (CLK_EN && period[c] >= 12'(FREQ_MIN)) begin
                    if (cnt[c] == 12'd0) begin
                        cnt[c]  <= period[c];
                        wptr[c] <= wptr[c] + 5'd1;
                    end else begin
                        cnt[c] <= cnt_nxt[c];
                    end
                end
            end
            if (CLK_EN) begin
                frame <= frame + 4'd1;
                if (frame == 4'd0) begin
                    for (int c = 0; c < 5; c++)
                        pcm[c] <= pcm_next[c];
                    OUT <= mix;
                end
            end
        end
    end

endmodule
